bleuart_tx_drain: RTL
=====================

# bleuart_tx_drain

FIFO-draining UART transmitter for the BLE link. Pops bytes from the BLE UART TX FIFO over its read port (`r_en` / `data_out` / `empty`) and serialises each byte as 8N1 onto the UART line to the BLE module. Honours the module's active-low CTS. It is the reader-side counterpart of the FIFO's write path, sitting between the TX FIFO and the `tx` pad.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2.
- `DATA_WIDTH`, 8: byte width; must match the FIFO's `DATA_WIDTH`.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  DATA_WIDTH  FIFO `data_out`; registered in the FIFO, valid the cycle after a pop.
- `fifo_r_en`  out  1  FIFO read enable; high for exactly one cycle per byte.
- `cts_n`  in  1  BLE clear-to-send, active-low, asynchronous to `clk`.
- `tx`  out  1  UART serial output; idle high.
- `busy`  out  1  high from leaving IDLE until the frame completes.
- `tx_done`  out  1  one-cycle pulse at the end of each stop bit.

## Operation
- `cts_n` passes through a 2-FF synchroniser (reset value 1, i.e. not clear) to give `cts_sync_n`.
- All outputs are registered or decoded from the Moore state.
- Reset values: `tx`=1, `busy`=0, `tx_done`=0, `fifo_r_en`=0, state=IDLE, counters=0.
- States (with `PARITY` only under the macro):
  - IDLE: `busy`=0. If `!fifo_empty && !cts_sync_n`, go to FETCH. Otherwise stay.
  - FETCH: `fifo_r_en`=1 for this single cycle; the FIFO pops at the closing edge. Go to LOAD.
  - LOAD: `shreg <= fifo_data`; `baud_cnt`=0, `bit_cnt`=0. Go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles. Go to DATA.
  - DATA: `tx`=`shreg[0]`, LSB first. After each `CLKS_PER_BIT` cycles, shift right and increment `bit_cnt`. After DATA_WIDTH bits, go to STOP (or PARITY).
  - PARITY: `tx`=XOR of the byte (even parity) for `CLKS_PER_BIT` cycles. Go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. On the last cycle, `tx_done`=1. Go to IDLE.
- Counter widths: `baud_cnt` is `$clog2(CLKS_PER_BIT)` bits and wraps at `CLKS_PER_BIT-1`. `bit_cnt` is `$clog2(DATA_WIDTH)+1` bits.
- CTS is sampled only in IDLE. Deasserting CTS mid-frame never aborts the frame; the current byte completes.
- A byte popped in FETCH is always transmitted unless reset intervenes.
- Reset mid-frame: `tx` returns to 1 immediately (asynchronous). The in-flight byte is lost; the FIFO has already advanced.
- `fifo_r_en` is never asserted while `fifo_empty`=1 is sampled in IDLE, so no underflow pop.

## Timing
- Pop to line: `fifo_r_en` high in cycle N. `fifo_data` is captured at the end of N+1. The `tx` falling edge (start bit) appears in cycle N+2.
- CTS latency: 2 cycles of synchroniser, plus 1 IDLE decision cycle, before FETCH.
- Frame length: (1 + DATA_WIDTH + 1) × `CLKS_PER_BIT` cycles, or (1 + DATA_WIDTH + 2) × `CLKS_PER_BIT` with parity.
- Back-to-back bytes: after the `tx_done` cycle, the minimum gap before the next start bit is 3 cycles (IDLE, FETCH, LOAD) of `tx`=1.
- `busy` rises the cycle FETCH is entered and falls the cycle IDLE is re-entered.

## Configuration
- `BLEUART_TX_PARITY_EN`
  - Defined: PARITY state compiled in. An even-parity bit is sent between the last data bit and the stop bit.
  - Undefined: no PARITY state, plain 8N1; the parity XOR logic is absent.

## Test plan
- Single byte (`CLKS_PER_BIT`=4, `cts_n`=0, FIFO holds 0xA5) -> exactly one `fifo_r_en` pulse. `tx` = 0, then 1,0,1,0,0,1,0,1, then 1, each bit held 4 cycles. `tx_done` pulses once, 40 cycles after the start bit begins. `busy` falls the next cycle.
- Back-to-back 0x00, 0xFF -> two `fifo_r_en` pulses. Exactly 3 idle-high cycles between the first stop bit's end and the second start bit. The second frame's data bits are all 1.
- Flow control: FIFO non-empty with `cts_n`=1 -> no `fifo_r_en`, `tx`=1 indefinitely. Drop `cts_n` -> FETCH occurs 3 cycles later. Raise `cts_n` mid-frame -> the frame completes intact and no further pop happens.
- Empty FIFO -> `fifo_r_en` stays 0, `busy` 0, `tx` 1. A byte written to the FIFO -> start bit within 6 cycles of `fifo_empty` falling, with `cts_n` held low.
- Reset mid-DATA (assert `rst`=0 at bit 3 of 0x3C) -> `tx`=1, `busy`=0, `tx_done`=0 immediately, without waiting for a clock. After release with the FIFO empty, no retransmission.
- With `BLEUART_TX_PARITY_EN`: 0x07 -> parity bit 1; 0xA5 -> parity bit 0. Frame length 44 cycles at `CLKS_PER_BIT`=4.

Source files
------------

// File: rtl/bleuart_tx_drain.sv
// FIFO-draining 8N1 UART transmitter for the BLE link, gated by the module's active-low CTS.
// Optional even parity bit compiled in with `define BLEUART_TX_PARITY_EN.
module bleuart_tx_drain #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    input  logic                  cts_n,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;
`ifdef BLEUART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd6;
`endif

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [BW-1:0]         baud_cnt;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  cts_meta_n;
    logic                  cts_sync_n;
    logic                  baud_wrap;

    assign baud_wrap = (baud_cnt == BAUD_LAST);

    // cts_n is asynchronous to clk; reset to "not clear" so nothing pops out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cts_meta_n <= 1'b1;
            cts_sync_n <= 1'b1;
        end else begin
            cts_meta_n <= cts_n;
            cts_sync_n <= cts_meta_n;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!fifo_empty && !cts_sync_n) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_START;
            S_START: if (baud_wrap) state_nxt = S_DATA;
            S_DATA: begin
                if (baud_wrap && bit_cnt == BIT_LAST) begin
`ifdef BLEUART_TX_PARITY_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_STOP;
`endif
                end
            end
`ifdef BLEUART_TX_PARITY_EN
            S_PARITY: if (baud_wrap) state_nxt = S_STOP;
`endif
            S_STOP:  if (baud_wrap) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Baud counter free-runs through the frame states; LOAD zeroes it so START gets a full bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    shreg    <= fifo_data;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
                S_START, S_STOP: begin
                    baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
                end
`ifdef BLEUART_TX_PARITY_EN
                S_PARITY: begin
                    baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
                end
`endif
                S_DATA: begin
                    baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
                    if (baud_wrap) begin
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    baud_cnt <= '0;
                end
            endcase
        end
    end

`ifdef BLEUART_TX_PARITY_EN
    // Data bits are shifted out, so the even-parity bit is latched with the byte
    logic par_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bit <= 1'b0;
        end else if (state == S_LOAD) begin
            par_bit <= ^fifo_data;
        end
    end
`endif

    // Moore decode: reset forces IDLE, so tx goes high without waiting for a clock
    always_comb begin
        tx = 1'b1;
        case (state)
            S_START:  tx = 1'b0;
            S_DATA:   tx = shreg[0];
`ifdef BLEUART_TX_PARITY_EN
            S_PARITY: tx = par_bit;
`endif
            default:  tx = 1'b1;
        endcase
    end

    assign fifo_r_en = (state == S_FETCH);
    assign busy      = (state != S_IDLE);
    assign tx_done   = (state == S_STOP) && baud_wrap;

endmodule
